mmio_io: RTL and testbench

- Parametrised memory-mapped I/O subsystem on the core data bus, alongside main memory at SoC top level.
- Owns N-digit 7-segment scanning, LED register, and debounced buttons with sticky press-edge flags.
- Top muxes `memrdata_o` with memory read data using `io_hit_o`.

---
 rtl/mmio_io_pkg.sv | 12 +
 rtl/mmio_io_btn_debounce.sv | 33 +++
 rtl/mmio_io.sv | 106 ++++++++++
 tb/tb_mmio_io.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg: register offsets and hex-to-segment table for the I/O window
package mmio_io_pkg;
  localparam logic [4:0] OFF_LED       = 5'h00;
  localparam logic [4:0] OFF_SEG_DATA  = 5'h04;
  localparam logic [4:0] OFF_SEG_EN    = 5'h08;
  localparam logic [4:0] OFF_BTN_STATE = 5'h0C;
  localparam logic [4:0] OFF_BTN_EDGE  = 5'h10;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/mmio_io_btn_debounce.sv
// btn_debounce: synchronises one raw button and accepts a new level after it holds DEBOUNCE_CYC cycles
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  logic s0_q, s1_q, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // count consecutive mismatch cycles; accept the new level on the final one
  always_comb begin
    cnt_d    = (s1_q == stable_q) ? '0 : (cnt_q == CW'(DEBOUNCE_CYC - 1)) ? '0 : cnt_q + 1'b1;
    stable_d = (s1_q != stable_q && cnt_q == CW'(DEBOUNCE_CYC - 1)) ? s1_q : stable_q;
  end
  // synchroniser and debounce state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s0_q     <= btn_i;
      s1_q     <= s0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign stable_o = stable_q;
endmodule

// File: rtl/mmio_io.sv
// mmio_io: memory-mapped LEDs, scanned 7-segment display and debounced buttons with sticky press flags
module mmio_io
  import mmio_io_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(32'hFFFF_0000),
  parameter int                N_DIGITS     = 4,
  parameter int                N_BUTTONS    = 4,
  parameter int                N_LEDS       = 4,
  parameter int                SCAN_DIV     = 50000,
  parameter int                DEBOUNCE_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memread_i,
  input  logic                 memwrite_i,
  input  logic [ADDR_W-1:0]    memaddr_i,
  input  logic [DATA_W-1:0]    memwdata_i,
  input  logic [N_BUTTONS-1:0] buttons_i,
  output logic [DATA_W-1:0]    memrdata_o,
  output logic                 io_hit_o,
  output logic [N_LEDS-1:0]    led_o,
  output logic [6:0]           seg7_seg_o,
  output logic [N_DIGITS-1:0]  seg7_an_o
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  logic [ADDR_W-1:0]     off;
  logic [4:0]            word;
  logic                  wr, rd, unused_bits;
  logic [N_BUTTONS-1:0]  btn_st;
  logic [N_LEDS-1:0]     led_q, led_d;
  logic [4*N_DIGITS-1:0] segd_q, segd_d;
  logic [N_DIGITS-1:0]   segen_q, segen_d, an_q, an_d;
  logic [N_BUTTONS-1:0]  edge_q, edge_d, prev_q;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  assign off         = memaddr_i - BASE_ADDR;
  assign io_hit_o    = off < ADDR_W'(32);
  assign word        = {off[4:2], 2'b00};
  assign wr          = memwrite_i && io_hit_o;
  assign rd          = memread_i && io_hit_o;
  assign unused_bits = ^{off, memwdata_i};
  genvar i;
  generate
    for (i = 0; i < N_BUTTONS; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (buttons_i[i]),
        .stable_o (btn_st[i])
      );
    end
  endgenerate
  // register writes, read mux, edge flags and scan sequencing
  always_comb begin
    led_d   = (wr && word == OFF_LED) ? memwdata_i[N_LEDS-1:0] : led_q;
    segd_d  = (wr && word == OFF_SEG_DATA) ? memwdata_i[4*N_DIGITS-1:0] : segd_q;
    segen_d = (wr && word == OFF_SEG_EN) ? memwdata_i[N_DIGITS-1:0] : segen_q;
    edge_d  = (edge_q & ~((wr && word == OFF_BTN_EDGE) ? memwdata_i[N_BUTTONS-1:0] : '0))
            | (btn_st & ~prev_q);
    rdata_d = !rd                      ? '0 :
              (word == OFF_LED)        ? DATA_W'(led_q) :
              (word == OFF_SEG_DATA)   ? DATA_W'(segd_q) :
              (word == OFF_SEG_EN)     ? DATA_W'(segen_q) :
              (word == OFF_BTN_STATE)  ? DATA_W'(btn_st) :
              (word == OFF_BTN_EDGE)   ? DATA_W'(edge_q) : '0;
    cnt_d   = (cnt_q == SW'(SCAN_DIV - 1)) ? '0 : cnt_q + 1'b1;
    idx_d   = (cnt_q != SW'(SCAN_DIV - 1)) ? idx_q : (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    an_d    = segen_q[idx_q] ? ~(N_DIGITS'(1) << idx_q) : '1;
    seg_d   = segen_q[idx_q] ? SEG_LUT[segd_q[{idx_q, 2'b00} +: 4]] : 7'h7F;
  end
  // all state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      segd_q  <= '0;
      segen_q <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
    end else begin
      led_q   <= led_d;
      segd_q  <= segd_d;
      segen_q <= segen_d;
      edge_q  <= edge_d;
      prev_q  <= btn_st;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end
  assign led_o      = led_q;
  assign memrdata_o = rdata_q;
  assign seg7_an_o  = an_q;
  assign seg7_seg_o = seg_q;
endmodule

// File: tb/tb_mmio_io.sv
// tb_mmio_io: directed checks of bus access, reset, scanning and button debounce/edge flags
module tb_mmio_io;
  logic        clk, rst, memread, memwrite, io_hit;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  buttons, led, an;
  logic [6:0]  seg;
  int total = 0;
  int bad = 0;
  logic [10:0] scan_exp [12] = '{
    {4'hE, 7'h40}, {4'hE, 7'h40},
    {4'hD, 7'h00}, {4'hD, 7'h00}, {4'hD, 7'h00},
    {4'hF, 7'h7F}, {4'hF, 7'h7F}, {4'hF, 7'h7F},
    {4'h7, 7'h30}, {4'h7, 7'h30}, {4'h7, 7'h30},
    {4'hE, 7'h40}
  };
  logic [3:0] prev_an;
  logic       found;

  mmio_io #(
    .BASE_ADDR    (32'hFFFF_0000),
    .SCAN_DIV     (3),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memread_i  (memread),
    .memwrite_i (memwrite),
    .memaddr_i  (addr),
    .memwdata_i (wdata),
    .buttons_i  (buttons),
    .memrdata_o (rdata),
    .io_hit_o   (io_hit),
    .led_o      (led),
    .seg7_seg_o (seg),
    .seg7_an_o  (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    addr     = a;
    wdata    = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    memread = 1'b1;
    addr    = a;
    tick();
    memread = 1'b0;
    chk(tag, rdata, e);
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0; buttons = '0;
    #2;
    chk("rst_led", {28'h0, led}, 32'h0);
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr(32'hFFFF_0000, 32'hFFFF_FFF5);
    chk("led_write", {28'h0, led}, 32'h5);
    rd("led_read", 32'hFFFF_0000, 32'h5);
    rd("reserved_read", 32'hFFFF_0018, 32'h0);
    addr = 32'hFFFF_001C; #1;
    chk("hit_top", {31'h0, io_hit}, 32'h1);
    addr = 32'hFFFF_0020; #1;
    chk("hit_past_top", {31'h0, io_hit}, 32'h0);
    memread = 1'b1; addr = 32'h0000_0000; #1;
    chk("hit_zero", {31'h0, io_hit}, 32'h0);
    tick(); memread = 1'b0;
    chk("miss_read", rdata, 32'h0);
    memread = 1'b1; memwrite = 1'b1; addr = 32'hFFFF_0000; wdata = 32'hA;
    tick();
    memread = 1'b0; memwrite = 1'b0;
    chk("rw_same_old", rdata, 32'h5);
    chk("rw_same_led", {28'h0, led}, 32'hA);
    memwrite = 1'b1; addr = 32'hFFFF_0000; wdata = 32'hF;
    #2 rst = 1'b1;
    #1;
    chk("midwr_led", {28'h0, led}, 32'h0);
    chk("midwr_an", {28'h0, an}, 32'hF);
    chk("midwr_seg", {25'h0, seg}, 32'h7F);
    chk("midwr_rdata", rdata, 32'h0);
    memwrite = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    chk("after_rst_led", {28'h0, led}, 32'h0);
    wr(32'hFFFF_0004, 32'h0000_3A80);
    wr(32'hFFFF_0008, 32'hFFFF_FFFB);
    rd("seg_data_read", 32'hFFFF_0004, 32'h3A80);
    rd("seg_en_read", 32'hFFFF_0008, 32'hB);
    prev_an = an;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (prev_an == 4'h7 && an == 4'hE) found = 1'b1;
      prev_an = an;
    end
    chk("scan_wrap_seen", {31'h0, found}, 32'h1);
    chk("scan_d0_first", {21'h0, an, seg}, {21'h0, 4'hE, 7'h40});
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("scan_step%0d", k), {21'h0, an, seg}, {21'h0, scan_exp[k]});
    end
    buttons[1] = 1'b1;
    repeat (3) tick();
    buttons[1] = 1'b0;
    repeat (10) tick();
    rd("glitch_state", 32'hFFFF_000C, 32'h0);
    rd("glitch_edge", 32'hFFFF_0010, 32'h0);
    buttons[2] = 1'b1;
    repeat (5) tick();
    rd("press_state_early", 32'hFFFF_000C, 32'h0);
    rd("press_state_on", 32'hFFFF_000C, 32'h4);
    repeat (3) tick();
    buttons[2] = 1'b0;
    rd("press_edge", 32'hFFFF_0010, 32'h4);
    repeat (10) tick();
    rd("release_state", 32'hFFFF_000C, 32'h0);
    rd("release_edge", 32'hFFFF_0010, 32'h4);
    buttons[2] = 1'b1;
    repeat (6) tick();
    wr(32'hFFFF_0010, 32'h4);
    rd("w1c_collide", 32'hFFFF_0010, 32'h4);
    wr(32'hFFFF_0010, 32'h4);
    rd("w1c_clear", 32'hFFFF_0010, 32'h0);
    rd("held_state", 32'hFFFF_000C, 32'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
